// File: rtl/serial_io_buffer_pkg.sv
// ----------------------------------------------------------------------------
// serial_io_buffer_pkg
// Shared widths and sizes for the serial I/O buffer and its FIFOs.
//   SERIAL_BYTE_W      : width of one serial byte
//   SERIAL_FIFO_DEPTH  : default entries per FIFO (power of two, >= 2)
//   SERIAL_FIFO_ADDR_W : log2 of the default depth
//   serial_byte_t      : convenience type for one byte
// ----------------------------------------------------------------------------
package serial_io_buffer_pkg;

    localparam int SERIAL_BYTE_W      = 8;
    localparam int SERIAL_FIFO_DEPTH  = 16;
    localparam int SERIAL_FIFO_ADDR_W = 4;

    typedef logic [SERIAL_BYTE_W-1:0] serial_byte_t;

endpackage : serial_io_buffer_pkg

// File: rtl/serial_io_buffer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with a separately tracked count.
//   clock, reset : system clock, synchronous active-high reset
//   push         : push request; commits when not full, or when full and a
//                  pop commits in the same cycle
//   pop_req      : pop request; commits only when the FIFO is non-empty
//   data_in      : byte written on a committed push
//   data_out     : head entry, forced to zero while empty
//   valid_out    : FIFO non-empty
//   count_out    : occupancy, 0..DEPTH
//   full_out     : occupancy equals DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop_req,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count_out,
    output logic              full_out
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic              do_pop;
    logic              do_push;

    // Decisions use pre-edge state. A pop frees a slot this cycle, so a
    // push into a full FIFO still commits when paired with a pop.
    always_comb begin
        do_pop  = valid_out && pop_req;
        do_push = push && ((count != FULL_COUNT) || do_pop);
    end

    // Storage carries no reset: stale entries are never visible because the
    // head is masked by valid and the pointers restart at zero.
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        valid_out = (count != '0);
        full_out  = (count == FULL_COUNT);
        count_out = count;
        data_out  = valid_out ? mem[rd_ptr] : '0;
    end

endmodule : sync_fifo

// File: rtl/serial_io_buffer.sv
// ----------------------------------------------------------------------------
// serial_io_buffer
// Byte buffering bridge between the processor serial port and an external
// UART byte interface. One FIFO per direction; the RX side also records a
// sticky overflow when a received byte has to be dropped.
//   clock, reset                 : system clock, synchronous active-high reset
//   rx_data_out / rx_valid_out   : RX head byte and non-empty, to processor
//   rx_rden_in                   : processor pops the RX head
//   tx_data_in / tx_wren_in      : processor pushes a TX byte
//   tx_ready_out                 : TX FIFO has room
//   ext_rx_data_in / _strobe_in  : byte arriving from the external UART
//   ext_tx_data_out / _valid_out : TX head byte offered to the external UART
//   ext_tx_ready_in              : external UART takes the offered byte
//   rx_overflow_out              : sticky, an RX byte was dropped
//   rx_count_out / tx_count_out  : FIFO occupancies, 0..DEPTH
// ----------------------------------------------------------------------------
module serial_io_buffer
    import serial_io_buffer_pkg::*;
#(
    parameter int DEPTH  = SERIAL_FIFO_DEPTH,
    parameter int ADDR_W = SERIAL_FIFO_ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [SERIAL_BYTE_W-1:0] rx_data_out,
    output logic                     rx_valid_out,
    input  logic                     rx_rden_in,
    input  logic [SERIAL_BYTE_W-1:0] tx_data_in,
    input  logic                     tx_wren_in,
    output logic                     tx_ready_out,
    input  logic [SERIAL_BYTE_W-1:0] ext_rx_data_in,
    input  logic                     ext_rx_strobe_in,
    output logic [SERIAL_BYTE_W-1:0] ext_tx_data_out,
    output logic                     ext_tx_valid_out,
    input  logic                     ext_tx_ready_in,
    output logic                     rx_overflow_out,
    output logic [ADDR_W:0]          rx_count_out,
    output logic [ADDR_W:0]          tx_count_out
);

    logic rx_full;
    logic tx_full;
    logic rx_overflow;

    sync_fifo #(
        .WIDTH  (SERIAL_BYTE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ext_rx_strobe_in),
        .pop_req   (rx_rden_in),
        .data_in   (ext_rx_data_in),
        .data_out  (rx_data_out),
        .valid_out (rx_valid_out),
        .count_out (rx_count_out),
        .full_out  (rx_full)
    );

    sync_fifo #(
        .WIDTH  (SERIAL_BYTE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_wren_in),
        .pop_req   (ext_tx_ready_in),
        .data_in   (tx_data_in),
        .data_out  (ext_tx_data_out),
        .valid_out (ext_tx_valid_out),
        .count_out (tx_count_out),
        .full_out  (tx_full)
    );

    // A full RX FIFO is always non-empty, so a strobe is dropped exactly
    // when it arrives while full and the processor is not popping.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_overflow <= 1'b0;
        end else if (ext_rx_strobe_in && rx_full && !rx_rden_in) begin
            rx_overflow <= 1'b1;
        end
    end

    always_comb begin
        rx_overflow_out = rx_overflow;
        tx_ready_out    = !tx_full;
    end

endmodule : serial_io_buffer
